bpsk_frame_sched: RTL

Frame scheduler for the BPSK transmit path. Runs on clk_sig (10 MHz) and generates the bit-rate timing. Each frame is sequenced as:
- a Barker-13 preamble, repeated PRE_REPS times;
- PAY_LEN payload bits pulled from the m-sequence source through a read handshake;
- GUARD_LEN silent bits.

It drives the carrier modulator with a registered data bit, a bit strobe and a carrier enable. It sits between the source/Barker generators and Carrier inside the transmitter.

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bit_tick_gen.sv | 35 +++
 rtl/bpsk_frame_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK frame scheduler.
package bpsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    GUARD = 2'd3
  } state_t;

  localparam int unsigned BARKER_LEN = 13;
  localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1111100110101;

  // Barker chip for preamble position idx (0 = first transmitted, MSB first)
  function automatic logic barker_bit(input logic [3:0] idx);
    logic [3:0] pos;
    pos = 4'(BARKER_LEN - 1) - idx;
    return BARKER13[pos];
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period tick counter: counts 0..DIV-1 while running, flags the
// second-to-last and last cycle of each bit. Clear forces the count to 0.
module bit_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic pre_last_c,
  output logic last_c
);

  localparam int unsigned TW = $clog2(DIV);

  logic [TW-1:0] cnt;

  // Modulo-DIV cycle counter within a bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= last_c ? '0 : cnt + TW'(1);
    end
  end

  // Position flags used to schedule registered strobes one cycle early
  always_comb begin
    pre_last_c = (cnt == TW'(DIV - 2));
    last_c     = (cnt == TW'(DIV - 1));
  end

endmodule

// File: rtl/bpsk_frame_sched.sv
// BPSK frame scheduler: Barker-13 preamble, handshaked payload, silent guard.
// Optional DBPSK payload encoding enabled by defining BPSK_FRAME_DIFF_ENC_EN.
module bpsk_frame_sched
  import bpsk_pkg::*;
#(
  parameter int unsigned DIV       = 10,
  parameter int unsigned PRE_REPS  = 1,
  parameter int unsigned PAY_LEN   = 64,
  parameter int unsigned GUARD_LEN = 2
) (
  input  logic clk_sig,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic src_bit,
  input  logic src_vld,
  output logic src_rd,
  output logic bit_sig,
  output logic bit_stb,
  output logic tx_en,
  output logic busy,
  output logic frame_done,
  output logic underflow
);

  localparam int unsigned CW = 16;
  localparam int unsigned RW = 4;
  localparam logic [CW-1:0] PRE_LAST = CW'(BARKER_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_LEN - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(PRE_REPS - 1);

  state_t        state, state_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic [RW-1:0] rep_cnt, rep_cnt_d;
  logic          bit_sig_d, bit_stb_d, src_rd_d, frame_done_d;
  logic          launch_c, take_c, clear_c;
  logic          raw_c, enc_c, raw_q;
  logic          pre_last_c, last_c;
  logic          run_c;

  assign run_c = (state != IDLE);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk        (clk_sig),
    .rst_n      (rst_n),
    .clear      (clear_c),
    .run        (run_c),
    .pre_last_c (pre_last_c),
    .last_c     (last_c)
  );

  // Raw payload bit: an invalid source repeats the previous raw bit
  assign raw_c = src_vld ? src_bit : raw_q;

`ifdef BPSK_FRAME_DIFF_ENC_EN
  logic dprev_q;

  assign enc_c = raw_c ^ dprev_q;

  // Last transmitted payload symbol; seeded with the final Barker chip (1)
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      dprev_q <= 1'b1;
    end else if (launch_c) begin
      dprev_q <= 1'b1;
    end else if (take_c) begin
      dprev_q <= enc_c;
    end
  end
`else
  assign enc_c = raw_c;
`endif

  // Next-state and next-output decode; strobes are set one cycle ahead
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    rep_cnt_d    = rep_cnt;
    bit_sig_d    = bit_sig;
    bit_stb_d    = 1'b0;
    src_rd_d     = 1'b0;
    frame_done_d = 1'b0;
    launch_c     = 1'b0;
    take_c       = 1'b0;
    clear_c      = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
      bit_sig_d = 1'b0;
      clear_c   = 1'b1;
    end else begin
      unique case (state)
        IDLE: launch_c = start;
        PRE: begin
          src_rd_d = pre_last_c && (bit_cnt == PRE_LAST) && (rep_cnt == REP_LAST);
          if (last_c) begin
            bit_stb_d = 1'b1;
            if (bit_cnt == PRE_LAST) begin
              bit_cnt_d = '0;
              if (rep_cnt == REP_LAST) begin
                state_d   = PAY;
                rep_cnt_d = '0;
                take_c    = 1'b1;
                bit_sig_d = enc_c;
              end else begin
                rep_cnt_d = rep_cnt + RW'(1);
                bit_sig_d = barker_bit(4'd0);
              end
            end else begin
              bit_cnt_d = bit_cnt + CW'(1);
              bit_sig_d = barker_bit(bit_cnt[3:0] + 4'd1);
            end
          end
        end
        PAY: begin
          src_rd_d = pre_last_c && (bit_cnt != PAY_LAST);
          if (last_c) begin
            bit_stb_d = 1'b1;
            if (bit_cnt == PAY_LAST) begin
              state_d   = GUARD;
              bit_cnt_d = '0;
              bit_sig_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt + CW'(1);
              take_c    = 1'b1;
              bit_sig_d = enc_c;
            end
          end
        end
        GUARD: begin
          frame_done_d = pre_last_c && (bit_cnt == GRD_LAST);
          if (last_c) begin
            if (bit_cnt == GRD_LAST) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
              launch_c  = start;
            end else begin
              bit_cnt_d = bit_cnt + CW'(1);
              bit_stb_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (launch_c) begin
        state_d   = PRE;
        bit_cnt_d = '0;
        rep_cnt_d = '0;
        bit_sig_d = barker_bit(4'd0);
        bit_stb_d = 1'b1;
        clear_c   = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Bit/rep counters and registered modulator outputs
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      bit_sig    <= 1'b0;
      bit_stb    <= 1'b0;
      src_rd     <= 1'b0;
      frame_done <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_d;
      rep_cnt    <= rep_cnt_d;
      bit_sig    <= bit_sig_d;
      bit_stb    <= bit_stb_d;
      src_rd     <= src_rd_d;
      frame_done <= frame_done_d;
      tx_en      <= (state_d == PRE) || (state_d == PAY);
      busy       <= (state_d != IDLE);
    end
  end

  // Last raw payload bit and sticky underflow flag, both reset per frame
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= 1'b0;
      underflow <= 1'b0;
    end else if (launch_c) begin
      raw_q     <= 1'b0;
      underflow <= 1'b0;
    end else if (take_c) begin
      raw_q <= raw_c;
      if (!src_vld) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
